// File: rtl/threadbrain_pkg.sv
// Shared types and entry-layout helpers for the write-back stage.
// Entry layout MSB->LSB: {valid, locked, dirty, addr[AW], data[DW]}.
package threadbrain_pkg;

    // Default geometry, used for the default-width flush entry view below
    localparam int DEF_AW   = 16;
    localparam int DEF_DW   = 16;

    // Data always sits at the bottom of an entry
    localparam int DATA_LSB = 0;

    function automatic int entry_width(input int aw, input int dw);
        return 3 + aw + dw;
    endfunction

    function automatic int valid_bit(input int aw, input int dw);
        return aw + dw + 2;
    endfunction

    function automatic int lock_bit(input int aw, input int dw);
        return aw + dw + 1;
    endfunction

    function automatic int dirty_bit(input int aw, input int dw);
        return aw + dw;
    endfunction

    function automatic int addr_lsb(input int dw);
        return dw;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2
    } drain_state_t;

    // Flush FIFO word for the default geometry: {addr, data}
    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } flush_entry_t;

endpackage

// File: rtl/wb_flush_fifo.sv
// Synchronous FIFO holding evicted dirty entries on their way to data memory.
// Head is valid whenever the FIFO is non-empty and stays put until popped.
module wb_flush_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CNTW  = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNTW-1:0]  count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNTW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign head  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/wb_rf_writeback.sv
// Write-back stage: merges one write per cycle into the packed register file,
// spills evicted dirty entries through a flush FIFO, and drains all dirty
// entries on request. Optional performance counters behind WB_PERF_EN.
module wb_rf_writeback
    import threadbrain_pkg::*;
#(
    parameter  int NCORES      = 4,
    parameter  int AW          = 16,
    parameter  int DW          = 16,
    parameter  int FLUSH_DEPTH = 4,
    localparam int EW          = entry_width(AW, DW),
    localparam int CW          = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES*EW-1:0] rf_in,
    output logic [NCORES*EW-1:0] rf_out,
    input  logic                 wb_en_in,
    input  logic [CW-1:0]        core_in,
    input  logic [AW-1:0]        ptr_in,
    input  logic [DW-1:0]        val_in,
    output logic                 wb_stall,
    input  logic                 drain_in,
    output logic                 drain_busy,
    output logic                 drain_done,
    output logic                 mem_wr_valid,
    input  logic                 mem_wr_ready,
    output logic [AW-1:0]        mem_wr_addr,
    output logic [DW-1:0]        mem_wr_data
`ifdef WB_PERF_EN
    ,
    output logic [31:0]          wb_count,
    output logic [31:0]          flush_count
`endif
);

    localparam int VALID_B  = valid_bit(AW, DW);
    localparam int LOCK_B   = lock_bit(AW, DW);
    localparam int DIRTY_B  = dirty_bit(AW, DW);
    localparam int ADDR_LSB = addr_lsb(DW);
    localparam int CNTW     = $clog2(FLUSH_DEPTH) + 1;

    localparam logic [CW:0]     CORE_LIM = (CW+1)'(NCORES);
    localparam logic [CW-1:0]   LAST_IDX = CW'(NCORES - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FLUSH_DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } flush_word_t;

    logic [NCORES*EW-1:0] rf_next;
    logic [EW-1:0]        entry;
    drain_state_t         state_q;
    drain_state_t         state_next;
    logic [CW-1:0]        scan_idx_q;
    logic [CW-1:0]        scan_idx_next;
    logic                 accept;
    logic                 scan_adv;
    logic                 wb_push;
    logic                 scan_push;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNTW-1:0]      fifo_count;
    flush_word_t          push_word;
    flush_word_t          head_word;

    assign wb_stall     = (fifo_count == FULL_CNT);
    assign accept       = wb_en_in & ~wb_stall & ({1'b0, core_in} < CORE_LIM);
    assign scan_adv     = (state_q == SCAN) & ~accept & ~fifo_full;
    assign fifo_push    = wb_push | scan_push;
    assign mem_wr_valid = ~fifo_empty;
    assign fifo_pop     = mem_wr_valid & mem_wr_ready;
    assign mem_wr_addr  = head_word.addr;
    assign mem_wr_data  = head_word.data;
    assign drain_busy   = (state_q != IDLE);

    // Build next RF: the accepted write wins its entry; otherwise the scanned entry may be flushed clean
    always_comb begin
        rf_next   = rf_in;
        entry     = '0;
        wb_push   = 1'b0;
        scan_push = 1'b0;
        push_word = '0;
        for (int c = 0; c < NCORES; c++) begin
            entry = rf_in[c*EW +: EW];
            if (accept && (CW'(c) == core_in)) begin
                if (entry[VALID_B] && (entry[ADDR_LSB +: AW] == ptr_in)) begin
                    entry[DATA_LSB +: DW] = val_in;
                    entry[DIRTY_B]        = 1'b1;
                    entry[LOCK_B]         = 1'b0;
                end else begin
                    if (entry[VALID_B] && entry[DIRTY_B]) begin
                        wb_push        = 1'b1;
                        push_word.addr = entry[ADDR_LSB +: AW];
                        push_word.data = entry[DATA_LSB +: DW];
                    end
                    entry = {1'b1, 1'b0, 1'b1, ptr_in, val_in};
                end
            end else if (scan_adv && (CW'(c) == scan_idx_q)) begin
                if (entry[VALID_B] && entry[DIRTY_B]) begin
                    scan_push      = 1'b1;
                    push_word.addr = entry[ADDR_LSB +: AW];
                    push_word.data = entry[DATA_LSB +: DW];
                    entry[DIRTY_B] = 1'b0;
                end
            end
            rf_next[c*EW +: EW] = entry;
        end
    end

    // Drain sequencer next state; drain_done fires in the WAIT cycle that sees the FIFO empty
    always_comb begin
        state_next    = state_q;
        scan_idx_next = scan_idx_q;
        drain_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (drain_in) begin
                    state_next    = SCAN;
                    scan_idx_next = '0;
                end
            end
            SCAN: begin
                if (scan_adv) begin
                    if (scan_idx_q == LAST_IDX) begin
                        state_next = WAIT;
                    end else begin
                        scan_idx_next = scan_idx_q + CW'(1);
                    end
                end
            end
            WAIT: begin
                if (fifo_empty) begin
                    state_next = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Register file and drain sequencer state
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_out     <= '0;
            state_q    <= IDLE;
            scan_idx_q <= '0;
        end else begin
            rf_out     <= rf_next;
            state_q    <= state_next;
            scan_idx_q <= scan_idx_next;
        end
    end

    wb_flush_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (FLUSH_DEPTH)
    ) u_flush_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_word),
        .pop       (fifo_pop),
        .head      (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef WB_PERF_EN
    // Saturating counts of accepted writes and memory flush handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_count    <= '0;
            flush_count <= '0;
        end else begin
            if (accept && (wb_count != 32'hFFFF_FFFF)) begin
                wb_count <= wb_count + 32'd1;
            end
            if (fifo_pop && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule
